memtrace_lane_serializer: RTL and testbench

//  Sits directly downstream of the memory-trace reader. Captures one multi-lane request

---
 rtl/memtrace_pkg.sv | 22 ++
 rtl/memtrace_lane_serializer_lane_prio_enc.sv | 22 ++
 rtl/memtrace_lane_serializer.sv | 137 +++++++++++++
 tb/tb_memtrace_lane_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memtrace_pkg.sv
// Shared widths, FSM state encoding and the per-lane request record
// used by the memory-trace lane serializer.
package memtrace_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_LOGSIZE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ser_state_e;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]    address;
    logic                         is_store;
    logic [DEF_LOGSIZE_WIDTH-1:0] size;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } trace_req_t;

endpackage

// File: rtl/memtrace_lane_serializer_lane_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest pending lane plus an any-set flag.
// Purely combinational.
module lane_prio_enc #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] i_mask,
  output logic [LANE_W-1:0]    o_idx,
  output logic                 o_any
);

  // Scan high-to-low so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = LANE_W'(i);
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/memtrace_lane_serializer.sv
// Captures one multi-lane trace bundle and issues its valid lanes lowest-first on a
// single valid/ready port; tracks outstanding requests and flags completion.
module memtrace_lane_serializer
  import memtrace_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LOGSIZE_WIDTH = DEF_LOGSIZE_WIDTH,
  parameter int MAX_INFLIGHT  = 8,
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic                              trace_ready,
  input  logic [NUM_LANES-1:0]              trace_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   trace_address,
  input  logic [NUM_LANES-1:0]              trace_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   trace_data,
  input  logic                              trace_finished,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [DATA_WIDTH-1:0]             mem_req_address,
  output logic                              mem_req_is_store,
  output logic [LOGSIZE_WIDTH-1:0]          mem_req_size,
  output logic [DATA_WIDTH-1:0]             mem_req_data,
  output logic [LANE_W-1:0]                 mem_req_lane,
  input  logic                              mem_resp_valid,
  output logic [CNT_W-1:0]                  inflight_count,
  output logic                              done,
  output logic                              resp_underflow
);

  ser_state_e           r_state;
  logic [NUM_LANES-1:0] r_pending;
  logic                 r_finished_seen;
  logic [CNT_W-1:0]     r_count;
  logic                 r_underflow;
  trace_req_t           r_lanes [NUM_LANES];

  logic [LANE_W-1:0]    w_sel;
  logic                 w_any;
  logic                 w_fire;
  logic                 w_last;
  logic [NUM_LANES-1:0] w_sel_mask;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_underflow_evt;

  lane_prio_enc #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_prio_enc (
    .i_mask (r_pending),
    .o_idx  (w_sel),
    .o_any  (w_any)
  );

  assign mem_req_valid = (r_state == ISSUE) && w_any && (r_count < CNT_W'(MAX_INFLIGHT));
  assign w_fire        = mem_req_valid && mem_req_ready;
  assign w_sel_mask    = NUM_LANES'(1) << w_sel;
  assign w_last        = (r_pending & ~w_sel_mask) == '0;

  // Payload is driven only from registered lane state, never from trace_* inputs.
  always_comb begin
    mem_req_address  = '0;
    mem_req_is_store = 1'b0;
    mem_req_size     = '0;
    mem_req_data     = '0;
    mem_req_lane     = '0;
    if (mem_req_valid) begin
      mem_req_address  = r_lanes[w_sel].address;
      mem_req_is_store = r_lanes[w_sel].is_store;
      mem_req_size     = r_lanes[w_sel].size;
      mem_req_data     = r_lanes[w_sel].data;
      mem_req_lane     = w_sel;
    end
  end

  always_comb begin
    w_count_nxt     = r_count;
    w_underflow_evt = 1'b0;
    if (w_fire && !mem_resp_valid) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_fire && mem_resp_valid) begin
      if (r_count == '0) w_underflow_evt = 1'b1;
      else               w_count_nxt     = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_pending       <= '0;
      r_finished_seen <= 1'b0;
      r_count         <= '0;
      r_underflow     <= 1'b0;
      for (int g = 0; g < NUM_LANES; g++) r_lanes[g] <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_underflow_evt) r_underflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (|trace_valid) begin
            for (int g = 0; g < NUM_LANES; g++) begin
              r_lanes[g].address  <= trace_address[DATA_WIDTH*g +: DATA_WIDTH];
              r_lanes[g].is_store <= trace_is_store[g];
              r_lanes[g].size     <= trace_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH];
              r_lanes[g].data     <= trace_data[DATA_WIDTH*g +: DATA_WIDTH];
            end
            r_pending       <= trace_valid;
            r_finished_seen <= trace_finished;
            r_state         <= ISSUE;
          end else if (trace_finished) begin
            r_state <= DRAIN;
          end
        end
        ISSUE: begin
          if (w_fire) begin
            r_pending <= r_pending & ~w_sel_mask;
            if (w_last) r_state <= r_finished_seen ? DRAIN : IDLE;
          end
        end
        // Look at the next count so a response in this cycle completes immediately.
        DRAIN: if (w_count_nxt == '0) r_state <= DONE;
        DONE:  r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trace_ready    = (r_state == IDLE);
  assign done           = (r_state == DONE);
  assign inflight_count = r_count;
  assign resp_underflow = r_underflow;

endmodule

// File: tb/tb_memtrace_lane_serializer.sv
// Scoreboard bench for memtrace_lane_serializer, built with an in-flight cap of 2.
module tb_memtrace_lane_serializer;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int MI = 2;
  localparam int LW = 2;
  localparam int CW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              trace_ready;
  logic [NL-1:0]     trace_valid;
  logic [DW*NL-1:0]  trace_address;
  logic [NL-1:0]     trace_is_store;
  logic [SW*NL-1:0]  trace_size;
  logic [DW*NL-1:0]  trace_data;
  logic              trace_finished;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [DW-1:0]     mem_req_address;
  logic              mem_req_is_store;
  logic [SW-1:0]     mem_req_size;
  logic [DW-1:0]     mem_req_data;
  logic [LW-1:0]     mem_req_lane;
  logic              mem_resp_valid;
  logic [CW-1:0]     inflight_count;
  logic              done;
  logic              resp_underflow;

  always #5 clock = ~clock;

  memtrace_lane_serializer #(
    .NUM_LANES     (NL),
    .DATA_WIDTH    (DW),
    .LOGSIZE_WIDTH (SW),
    .MAX_INFLIGHT  (MI)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .trace_ready      (trace_ready),
    .trace_valid      (trace_valid),
    .trace_address    (trace_address),
    .trace_is_store   (trace_is_store),
    .trace_size       (trace_size),
    .trace_data       (trace_data),
    .trace_finished   (trace_finished),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_address  (mem_req_address),
    .mem_req_is_store (mem_req_is_store),
    .mem_req_size     (mem_req_size),
    .mem_req_data     (mem_req_data),
    .mem_req_lane     (mem_req_lane),
    .mem_resp_valid   (mem_resp_valid),
    .inflight_count   (inflight_count),
    .done             (done),
    .resp_underflow   (resp_underflow)
  );

  typedef struct {
    logic [LW-1:0] lane;
    logic [DW-1:0] addr;
    logic          st;
    logic [SW-1:0] size;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_fire = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every accepted request is matched against the oldest expected lane.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && mem_req_valid && mem_req_ready) begin
      n_fire++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_fire", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_lane", 64'(mem_req_lane), 64'(e.lane));
        chk("sb_addr", mem_req_address, e.addr);
        chk("sb_store", 64'(mem_req_is_store), 64'(e.st));
        chk("sb_size", 64'(mem_req_size), 64'(e.size));
        chk("sb_data", mem_req_data, e.data);
      end
    end
  end

  // Valid lane g gets base + g*0x100; invalid lanes carry junk that must never issue.
  task automatic send(input logic [NL-1:0] v, input logic fin, input logic [63:0] base);
    int k;
    exp_t e;
    for (int g = 0; g < NL; g++) begin
      trace_address[DW*g +: DW] = v[g] ? base + 64'(g) * 64'h100 : 64'hDEAD_0000 + 64'(g);
      trace_data[DW*g +: DW]    = 64'hD000_0000_0000_0000 + base + 64'(g);
      trace_is_store[g]         = (g % 2) == 1;
      trace_size[SW*g +: SW]    = 8'hF0 + 8'(g);
      if (v[g]) begin
        e.lane = LW'(g);
        e.addr = base + 64'(g) * 64'h100;
        e.st   = (g % 2) == 1;
        e.size = 8'hF0 + 8'(g);
        e.data = 64'hD000_0000_0000_0000 + base + 64'(g);
        sb_q.push_back(e);
      end
    end
    trace_valid    = v;
    trace_finished = fin;
    k = 0;
    @(negedge clock);
    while (!trace_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!trace_ready) chk("send_timeout", 64'(trace_ready), 64'd1);
    @(posedge clock) #1;
    trace_valid    = '0;
    trace_finished = 1'b0;
  endtask

  task automatic resp(input int n);
    mem_resp_valid = 1'b1;
    repeat (n) @(posedge clock) #1;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    int f0;
    reset          = 1'b1;
    trace_valid    = '0;
    trace_address  = '0;
    trace_is_store = '0;
    trace_size     = '0;
    trace_data     = '0;
    trace_finished = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_trace_ready", 64'(trace_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_addr", mem_req_address, 64'd0);
    chk("rst_inflight", 64'(inflight_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_underflow", 64'(resp_underflow), 64'd0);

    // Sparse bundle: lanes 1 and 3 on consecutive cycles.
    @(posedge clock) #1;
    mem_req_ready = 1'b1;
    send(4'b1010, 1'b0, 64'h0);
    @(negedge clock);
    chk("t1_valid_t1", 64'(mem_req_valid), 64'd1);
    chk("t1_lane_t1", 64'(mem_req_lane), 64'd1);
    chk("t1_addr_t1", mem_req_address, 64'h100);
    @(negedge clock);
    chk("t1_lane_t2", 64'(mem_req_lane), 64'd3);
    chk("t1_addr_t2", mem_req_address, 64'h300);
    @(negedge clock);
    chk("t1_ready_t3", 64'(trace_ready), 64'd1);
    chk("t1_inflight", 64'(inflight_count), 64'd2);
    @(posedge clock) #1;
    resp(2);

    // Backpressure holds the payload stable.
    mem_req_ready = 1'b0;
    send(4'b0001, 1'b0, 64'h400);
    f0 = n_fire;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t2_hold_valid", 64'(mem_req_valid), 64'd1);
      chk("t2_hold_addr", mem_req_address, 64'h400);
      chk("t2_hold_lane", 64'(mem_req_lane), 64'd0);
    end
    @(posedge clock) #1 mem_req_ready = 1'b1;
    @(posedge clock) #1 mem_req_ready = 1'b0;
    @(negedge clock);
    chk("t2_fires", 64'(n_fire - f0), 64'd1);
    chk("t2_inflight", 64'(inflight_count), 64'd1);
    @(posedge clock) #1;
    resp(1);

    // In-flight cap of 2 stalls a full bundle until responses return.
    mem_req_ready = 1'b1;
    f0 = n_fire;
    send(4'b1111, 1'b0, 64'h1000);
    repeat (4) @(negedge clock);
    chk("t3_cap_valid", 64'(mem_req_valid), 64'd0);
    chk("t3_cap_inflight", 64'(inflight_count), 64'd2);
    chk("t3_cap_fires", 64'(n_fire - f0), 64'd2);
    @(posedge clock) #1;
    resp(1);
    @(negedge clock);
    chk("t3_lane2_valid", 64'(mem_req_valid), 64'd1);
    chk("t3_lane2_lane", 64'(mem_req_lane), 64'd2);
    @(posedge clock) #1;
    resp(1);
    @(negedge clock);
    chk("t3_lane3_lane", 64'(mem_req_lane), 64'd3);
    @(posedge clock) #1;
    resp(2);
    @(negedge clock);
    chk("t3_drained", 64'(inflight_count), 64'd0);

    // Simultaneous fire and response, then an underflowing response.
    @(posedge clock) #1;
    send(4'b0001, 1'b0, 64'h2000);
    send(4'b0010, 1'b0, 64'h3000);
    resp(1);
    @(negedge clock);
    chk("t5_fire_and_resp", 64'(inflight_count), 64'd1);
    @(posedge clock) #1;
    resp(1);
    @(negedge clock);
    chk("t5_count_zero", 64'(inflight_count), 64'd0);
    chk("t5_no_underflow", 64'(resp_underflow), 64'd0);
    @(posedge clock) #1;
    resp(1);
    @(negedge clock);
    chk("t5_underflow", 64'(resp_underflow), 64'd1);
    chk("t5_count_stays0", 64'(inflight_count), 64'd0);

    // Reset while three lanes are still pending.
    @(posedge clock) #1;
    mem_req_ready = 1'b0;
    send(4'b0111, 1'b0, 64'h4000);
    @(negedge clock);
    chk("t6_pre_valid", 64'(mem_req_valid), 64'd1);
    @(posedge clock) #1 reset = 1'b1;
    @(posedge clock) #1 reset = 1'b0;
    sb_q.delete();
    @(negedge clock);
    chk("t6_valid", 64'(mem_req_valid), 64'd0);
    chk("t6_trace_ready", 64'(trace_ready), 64'd1);
    chk("t6_inflight", 64'(inflight_count), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_underflow_clr", 64'(resp_underflow), 64'd0);

    // Finished flag carried with data: issue, drain, done.
    @(posedge clock) #1;
    mem_req_ready = 1'b1;
    send(4'b0001, 1'b1, 64'h5000);
    @(negedge clock);
    @(posedge clock) #1;
    @(negedge clock);
    chk("t4_drain_done", 64'(done), 64'd0);
    chk("t4_drain_ready", 64'(trace_ready), 64'd0);
    chk("t4_drain_inflight", 64'(inflight_count), 64'd1);
    @(posedge clock) #1;
    resp(1);
    @(negedge clock);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_done_ready", 64'(trace_ready), 64'd0);
    chk("t4_done_inflight", 64'(inflight_count), 64'd0);
    repeat (3) @(negedge clock);
    chk("t4_done_sticky", 64'(done), 64'd1);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
